// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, lane masks and the responder FSM state codes.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  localparam logic [WB_SELW-1:0] WB_SEL_ALL = 4'b1111;

  // Responder FSM encodings, kept as plain constants for legacy tool flows.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/sp_ram_bytewe.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// The read register is cleared by reset; the array itself is never cleared.
module sp_ram_bytewe
  import wb_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      addr,
  input  logic [WB_DW-1:0]   wdata,
  input  logic [WB_SELW-1:0] we,
  input  logic               re,
  output logic [WB_DW-1:0]   rdata
);

  logic [WB_DW-1:0] mem_q [0:(2**AW)-1];
  logic [WB_DW-1:0] rdata_q;
  logic [WB_DW-1:0] rdata_d;

  // Byte-lane write into the array; only enabled lanes change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_SELW; i++) begin
      if (we[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Next read value: load the addressed word on a read strobe, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register; held between reads so the bus sees stable data after ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {WB_DW{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/slave_wb_mem.sv
// Wishbone classic responder in front of a word-addressed byte-writable RAM.
// Optional build macro WB_ERR_EN: adds wbs_err_o and flags accesses beyond the window
// instead of wrapping them onto the RAM.
// A zero-wait-state transfer still passes through WAIT with the counter at zero, so the
// registered ack always lands WAIT_STATES+1 cycles after the request edge.
module slave_wb_mem
  import wb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        wbs_adr_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  input  logic [WB_SELW-1:0] wbs_sel_i,
  input  logic               wbs_we_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  output logic [WB_DW-1:0]   wbs_dat_o,
  output logic               wbs_ack_o
`ifdef WB_ERR_EN
  ,
  output logic               wbs_err_o
`endif
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic                  we_q, we_d;
  logic [WB_SELW-1:0]    sel_q, sel_d;
  logic [WB_DW-1:0]      dat_q, dat_d;
  logic                  ack_q, ack_d;

  logic [31:0]           offset_s;
  logic                  req_s;
  logic                  access_ok_s;
  logic [WB_SELW-1:0]    ram_we_s;
  logic                  ram_re_s;
  logic                  unused_s;

  assign offset_s = wbs_adr_i - BASE_ADDR;
  assign req_s    = wbs_cyc_i & wbs_stb_i;
  // Byte-offset bits and, without the error check, the bits above the window are don't-care.
  assign unused_s = ^{offset_s[1:0], offset_s[31:ADDR_WIDTH+2]};

`ifdef WB_ERR_EN
  logic oor_q, oor_d;
  logic err_q, err_d;
  assign access_ok_s = ~oor_q;
  assign wbs_err_o   = err_q;
`else
  assign access_ok_s = 1'b1;
`endif

  // Transfer sequencing: latch request, count wait states, fire one response cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    we_d     = we_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    ack_d    = 1'b0;
    ram_we_s = {WB_SELW{1'b0}};
    ram_re_s = 1'b0;
`ifdef WB_ERR_EN
    oor_d    = oor_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          word_d  = offset_s[ADDR_WIDTH+1:2];
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          dat_d   = wbs_dat_i;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
`ifdef WB_ERR_EN
          oor_d   = |offset_s[31:ADDR_WIDTH+2];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          // Master abandoned the cycle: drop it without touching the RAM.
          state_d = ST_IDLE;
        end else if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_RESP;
          ack_d   = access_ok_s;
`ifdef WB_ERR_EN
          err_d   = ~access_ok_s;
`endif
          if (access_ok_s) begin
            if (we_q) begin
              ram_we_s = sel_q;
            end else begin
              ram_re_s = 1'b1;
            end
          end else begin
            ram_re_s = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      ST_RESP: begin
        // Response lasts one cycle; the still-high strobe is not a new request.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, counter, latched request and response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      word_q  <= {ADDR_WIDTH{1'b0}};
      we_q    <= 1'b0;
      sel_q   <= {WB_SELW{1'b0}};
      dat_q   <= {WB_DW{1'b0}};
      ack_q   <= 1'b0;
`ifdef WB_ERR_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
`ifdef WB_ERR_EN
      oor_q   <= oor_d;
      err_q   <= err_d;
`endif
    end
  end

  assign wbs_ack_o = ack_q;

  sp_ram_bytewe #(
    .AW (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (word_q),
    .wdata (dat_q),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .rdata (wbs_dat_o)
  );

endmodule

// File: tb/tb_slave_wb_mem.sv
// Directed bench for slave_wb_mem: three instances (1, 0 and 3 wait states) on a shared bus,
// each selected by its own cyc. Expected read data goes into a scoreboard queue when the read
// is issued and is popped when the ack arrives.
module tb_slave_wb_mem;

  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic [2:0]  cyc;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rd [3];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb_q [$];
  int          ws_tab [3] = '{1, 0, 3};

  always #5 clk = ~clk;

  slave_wb_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) u_d0 (
    .clk(clk), .rst_n(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_we_i(we), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb), .wbs_dat_o(rd[0]), .wbs_ack_o(ack[0])
`ifdef WB_ERR_EN
    , .wbs_err_o(err[0])
`endif
  );

  slave_wb_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) u_d1 (
    .clk(clk), .rst_n(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_we_i(we), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb), .wbs_dat_o(rd[1]), .wbs_ack_o(ack[1])
`ifdef WB_ERR_EN
    , .wbs_err_o(err[1])
`endif
  );

  slave_wb_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(3), .BASE_ADDR(32'h0000_0000)) u_d2 (
    .clk(clk), .rst_n(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_we_i(we), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb), .wbs_dat_o(rd[2]), .wbs_ack_o(ack[2])
`ifdef WB_ERR_EN
    , .wbs_err_o(err[2])
`endif
  );

`ifndef WB_ERR_EN
  assign err = 3'b000;
`endif

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer on instance d; checks latency, response kind, pulse width, read data.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] dv,
                      input logic [3:0] s, input logic exp_err, input logic [31:0] exp_rd);
    int          n;
    logic        got_ack;
    logic        got_err;
    logic [31:0] prev;
    logic [31:0] exp_v;
    prev = rd[d];
    if (!w && !exp_err) sb_q.push_back(exp_rd);
    @(posedge clk); #1;
    adr = a; we = w; wdat = dv; sel = s; stb = 1'b1; cyc[d] = 1'b1;
    n = 0; got_ack = 1'b0; got_err = 1'b0;
    while (!got_ack && !got_err && n < 40) begin
      @(posedge clk); #1;
      n++;
      got_ack = ack[d];
      got_err = err[d];
    end
    check32("latency", n - 1, ws_tab[d] + 1);
    check32("resp_kind", {30'd0, got_err, got_ack}, exp_err ? 32'd2 : 32'd1);
    if (got_ack && !w) begin
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : ~rd[d];
      check32("rdata", rd[d], exp_v);
    end
    if (got_err) check32("err_dat_hold", rd[d], prev);
    @(posedge clk); #1;
    check32("pulse_width", {30'd0, err[d], ack[d]}, 32'd0);
    stb = 1'b0; cyc[d] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check32("no_second_resp", {30'd0, err[d], ack[d]}, 32'd0);
    end
  endtask

  // Start a write, then drop cyc/stb while it is still waiting; no response may follow.
  task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] dv);
    @(posedge clk); #1;
    adr = a; we = 1'b1; wdat = dv; sel = 4'b1111; stb = 1'b1; cyc[d] = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc[d] = 1'b0;
    repeat (ws_tab[d] + 3) begin
      @(posedge clk); #1;
      check32("abort_no_resp", {30'd0, err[d], ack[d]}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b1; adr = 32'h0; wdat = 32'h0; sel = 4'h0; we = 1'b0; stb = 1'b0; cyc = 3'b000;
    #2 rst_n = 1'b0;
    #10;
    check32("reset_ack", {29'd0, ack}, 32'd0);
    check32("reset_err", {29'd0, err}, 32'd0);
    check32("reset_dat0", rd[0], 32'd0);
    check32("reset_dat2", rd[2], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-word write and read back, one wait state.
    xfer(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0);
    xfer(0, 32'h0000_0010, 1'b0, 32'h0,        4'b1111, 1'b0, 32'hDEAD_BEEF);

    // Byte lanes: only lanes 0 and 2 take the new data.
    xfer(0, 32'h0000_0020, 1'b1, 32'h1122_3344, 4'b1111, 1'b0, 32'h0);
    xfer(0, 32'h0000_0020, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
    xfer(0, 32'h0000_0022, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h11BB_33DD);

    // Zero wait states with a non-zero window base.
    xfer(1, 32'h0000_1008, 1'b1, 32'h5A5A_0001, 4'b1111, 1'b0, 32'h0);
    xfer(1, 32'h0000_1008, 1'b0, 32'h0,         4'b1111, 1'b0, 32'h5A5A_0001);

    // Three wait states; write right after read returns the new data; sel=0000 write changes nothing.
    xfer(2, 32'h0000_0040, 1'b1, 32'h1234_5678, 4'b1111, 1'b0, 32'h0);
    xfer(2, 32'h0000_0040, 1'b0, 32'h0,         4'b1111, 1'b0, 32'h1234_5678);
    xfer(2, 32'h0000_0040, 1'b1, 32'h9ABC_DEF0, 4'b1111, 1'b0, 32'h0);
    xfer(2, 32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0);
    xfer(2, 32'h0000_0040, 1'b0, 32'h0,         4'b1111, 1'b0, 32'h9ABC_DEF0);

    // Abort in WAIT leaves the word untouched.
    xfer(0, 32'h0000_0030, 1'b1, 32'h7777_7777, 4'b1111, 1'b0, 32'h0);
    abort_write(0, 32'h0000_0030, 32'h0000_0055);
    xfer(0, 32'h0000_0030, 1'b0, 32'h0,         4'b1111, 1'b0, 32'h7777_7777);

    // Asynchronous reset while a write waits: outputs clear at once, RAM keeps its contents.
    @(posedge clk); #1;
    adr = 32'h0000_0040; we = 1'b1; wdat = 32'h0BAD_F00D; sel = 4'b1111; stb = 1'b1; cyc[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check32("async_rst_ack", {29'd0, ack}, 32'd0);
    check32("async_rst_dat2", rd[2], 32'd0);
    check32("async_rst_dat0", rd[0], 32'd0);
    stb = 1'b0; cyc = 3'b000;
    #10 rst_n = 1'b1;
    xfer(2, 32'h0000_0040, 1'b0, 32'h0, 4'b1111, 1'b0, 32'h9ABC_DEF0);
    xfer(0, 32'h0000_0010, 1'b0, 32'h0, 4'b1111, 1'b0, 32'hDEAD_BEEF);

    // One word past the window.
    xfer(1, 32'h0000_1000, 1'b1, 32'h0102_0304, 4'b1111, 1'b0, 32'h0);
    xfer(1, 32'h0000_1000, 1'b0, 32'h0,         4'b1111, 1'b0, 32'h0102_0304);
`ifdef WB_ERR_EN
    xfer(1, 32'h0000_1100, 1'b1, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'h0);
    xfer(1, 32'h0000_1000, 1'b0, 32'h0,         4'b1111, 1'b0, 32'h0102_0304);
`else
    xfer(1, 32'h0000_1100, 1'b1, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0);
    xfer(1, 32'h0000_1000, 1'b0, 32'h0,         4'b1111, 1'b0, 32'hCAFE_F00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
